// File: rtl/stereo_echo.sv
// Stereo echo stage: per audio frame, mixes a delayed sample from a block-RAM ring
// buffer into the dry input and writes a feedback-mixed sample back.
module stereo_echo #(
    parameter int DEPTH_LOG2 = 14,
    parameter int DATA_W     = 16,
    parameter int GAIN_W     = 8
) (
    input  logic                  mclk,
    input  logic                  rst_n,
    input  logic                  ws_in,
    input  logic [DATA_W-1:0]     in_l,
    input  logic [DATA_W-1:0]     in_r,
    input  logic [DEPTH_LOG2-1:0] delay_len,
    input  logic [GAIN_W-1:0]     fb_gain,
    input  logic [GAIN_W-1:0]     mix_gain,
    input  logic                  bypass,
    output logic [DATA_W-1:0]     out_l,
    output logic [DATA_W-1:0]     out_r,
    output logic                  out_valid,
    output logic                  busy
);

    localparam int AW = DEPTH_LOG2 + 1;
    localparam int FW = DEPTH_LOG2 + 1;
    localparam int PW = DATA_W + GAIN_W + 1;
    localparam int SW = DATA_W + 1;
    localparam logic [FW-1:0] FRAMES_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [2:0] {
        IDLE, RD_L, WAIT_L, WR_L, RD_R, WAIT_R, WR_R, DONE
    } state_t;

    state_t state_q, state_d;

    logic                  ws_q, ws_d;
    logic [DATA_W-1:0]     in_l_q, in_l_d, in_r_q, in_r_d;
    logic [DEPTH_LOG2-1:0] delay_q, delay_d;
    logic [GAIN_W-1:0]     fb_q, fb_d, mix_q, mix_d;
    logic                  bypass_q, bypass_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [FW-1:0]         frames_q, frames_d;
    logic [DATA_W-1:0]     res_l_q, res_l_d, res_r_q, res_r_d;
    logic [DATA_W-1:0]     wr_val_q, wr_val_d;
    logic [DATA_W-1:0]     out_l_q, out_l_d, out_r_q, out_r_d;

    logic [DATA_W-1:0]     ram_q [0:(2**AW)-1];
    logic [DATA_W-1:0]     ram_rdata_q;
    logic [AW-1:0]         ram_addr;
    logic                  ram_we;

    logic                  trig;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  fill_ok;
    logic [DATA_W-1:0]     x, d;
    logic signed [PW-1:0]  d_ext, mix_ext, fb_ext, prod_mix, prod_fb;
    logic signed [SW-1:0]  x_ext, wet, fbk, sum_out, sum_wr;
    logic [DATA_W-1:0]     out_val, wr_val;

    // Clip a DATA_W+1 bit sum back into DATA_W bits.
    function automatic logic [DATA_W-1:0] sat_sample(input logic [SW-1:0] s);
        if (s[SW-1] != s[SW-2])
            return s[SW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        return s[DATA_W-1:0];
    endfunction

    assign trig = (state_q == IDLE) && ws_q && !ws_in;

    // FSM: state register
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (trig) state_d = RD_L;
            RD_L:    state_d = WAIT_L;
            WAIT_L:  state_d = WR_L;
            WR_L:    state_d = RD_R;
            RD_R:    state_d = WAIT_R;
            WAIT_R:  state_d = WR_R;
            WR_R:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        ram_we    = (state_q == WR_L) || (state_q == WR_R);
        rd_ptr    = wr_ptr_q - delay_q;
        case (state_q)
            RD_L:    ram_addr = {1'b0, rd_ptr};
            WR_L:    ram_addr = {1'b0, wr_ptr_q};
            RD_R:    ram_addr = {1'b1, rd_ptr};
            WR_R:    ram_addr = {1'b1, wr_ptr_q};
            default: ram_addr = {1'b0, wr_ptr_q};
        endcase
    end

    always_ff @(posedge mclk) begin
        if (ram_we) ram_q[ram_addr] <= wr_val_q;
        ram_rdata_q <= ram_q[ram_addr];
    end

    // Datapath evaluated in WAIT_x, when the delayed sample has arrived from RAM.
    always_comb begin
        x        = (state_q == WAIT_R) ? in_r_q : in_l_q;
        fill_ok  = (delay_q != '0) && (frames_q >= {1'b0, delay_q});
        d        = fill_ok ? ram_rdata_q : '0;
        d_ext    = {{(PW-DATA_W){d[DATA_W-1]}}, d};
        mix_ext  = {{(PW-GAIN_W){1'b0}}, mix_q};
        fb_ext   = {{(PW-GAIN_W){1'b0}}, fb_q};
        prod_mix = d_ext * mix_ext;
        prod_fb  = d_ext * fb_ext;
        // Dropping the low GAIN_W bits of a signed product is a floor shift.
        wet      = prod_mix[PW-1:GAIN_W];
        fbk      = prod_fb[PW-1:GAIN_W];
        x_ext    = {x[DATA_W-1], x};
        sum_out  = x_ext + wet;
        sum_wr   = x_ext + fbk;
        out_val  = bypass_q ? x : sat_sample(sum_out);
        wr_val   = bypass_q ? x : sat_sample(sum_wr);
    end

    always_comb begin
        ws_d     = ws_in;
        in_l_d   = trig ? in_l      : in_l_q;
        in_r_d   = trig ? in_r      : in_r_q;
        delay_d  = trig ? delay_len : delay_q;
        fb_d     = trig ? fb_gain   : fb_q;
        mix_d    = trig ? mix_gain  : mix_q;
        bypass_d = trig ? bypass    : bypass_q;
        res_l_d  = (state_q == WAIT_L) ? out_val : res_l_q;
        res_r_d  = (state_q == WAIT_R) ? out_val : res_r_q;
        wr_val_d = (state_q == WAIT_L || state_q == WAIT_R) ? wr_val : wr_val_q;
        // Outputs are loaded together so they become visible in the DONE cycle.
        out_l_d  = (state_q == WR_R) ? res_l_q : out_l_q;
        out_r_d  = (state_q == WR_R) ? res_r_q : out_r_q;
        wr_ptr_d = (state_q == DONE) ? wr_ptr_q + 1'b1 : wr_ptr_q;
        frames_d = (state_q == DONE && frames_q != FRAMES_MAX) ? frames_q + 1'b1 : frames_q;
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            ws_q     <= 1'b0;
            in_l_q   <= '0;
            in_r_q   <= '0;
            delay_q  <= '0;
            fb_q     <= '0;
            mix_q    <= '0;
            bypass_q <= 1'b0;
            res_l_q  <= '0;
            res_r_q  <= '0;
            wr_val_q <= '0;
            out_l_q  <= '0;
            out_r_q  <= '0;
            wr_ptr_q <= '0;
            frames_q <= '0;
        end else begin
            ws_q     <= ws_d;
            in_l_q   <= in_l_d;
            in_r_q   <= in_r_d;
            delay_q  <= delay_d;
            fb_q     <= fb_d;
            mix_q    <= mix_d;
            bypass_q <= bypass_d;
            res_l_q  <= res_l_d;
            res_r_q  <= res_r_d;
            wr_val_q <= wr_val_d;
            out_l_q  <= out_l_d;
            out_r_q  <= out_r_d;
            wr_ptr_q <= wr_ptr_d;
            frames_q <= frames_d;
        end
    end

    assign out_l = out_l_q;
    assign out_r = out_r_q;

endmodule

// File: tb/tb_stereo_echo.sv
// Directed bench for stereo_echo: latency/busy timing, echo and feedback arithmetic,
// saturation, bypass, fill guard, pointer wrap and asynchronous reset mid-frame.
module tb_stereo_echo;

    localparam int DL2 = 7;

    logic           mclk = 1'b0;
    logic           rst_n;
    logic           ws_in;
    logic [15:0]    in_l, in_r;
    logic [DL2-1:0] delay_len;
    logic [7:0]     fb_gain, mix_gain;
    logic           bypass;
    logic [15:0]    out_l, out_r;
    logic           out_valid, busy;

    stereo_echo #(.DEPTH_LOG2(DL2), .DATA_W(16), .GAIN_W(8)) dut (
        .mclk(mclk), .rst_n(rst_n), .ws_in(ws_in),
        .in_l(in_l), .in_r(in_r), .delay_len(delay_len),
        .fb_gain(fb_gain), .mix_gain(mix_gain), .bypass(bypass),
        .out_l(out_l), .out_r(out_r), .out_valid(out_valid), .busy(busy)
    );

    always #5 mclk = ~mclk;

    int checks = 0;
    int errors = 0;
    int dl, fb, mix;
    bit byp;
    int nfr;
    int hl [0:1023];
    int hr [0:1023];

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Floor division by 256 of d*g.
    function automatic int mulsh(input int dv, input int g);
        int p;
        p = dv * g;
        if (p >= 0) return p / 256;
        return -((-p + 255) / 256);
    endfunction

    task automatic model_frame(input int l, input int r, output int el, output int er);
        int dlv, drv;
        dlv = (dl != 0 && nfr >= dl) ? hl[nfr-dl] : 0;
        drv = (dl != 0 && nfr >= dl) ? hr[nfr-dl] : 0;
        el = byp ? l : sat16(l + mulsh(dlv, mix));
        er = byp ? r : sat16(r + mulsh(drv, mix));
        hl[nfr] = byp ? l : sat16(l + mulsh(dlv, fb));
        hr[nfr] = byp ? r : sat16(r + mulsh(drv, fb));
        nfr++;
    endtask

    task automatic run_frame(input int l, input int r, input int el, input int er, input string tag);
        int vcnt, vpos, bcnt;
        logic [15:0] sl, sr;
        @(negedge mclk);
        ws_in = 1'b1;
        @(negedge mclk);
        ws_in = 1'b0;
        in_l = 16'(l); in_r = 16'(r);
        delay_len = DL2'(dl); fb_gain = 8'(fb); mix_gain = 8'(mix); bypass = byp;
        @(posedge mclk);
        #1;
        in_l = 16'($urandom); in_r = 16'($urandom);
        delay_len = DL2'($urandom); fb_gain = 8'($urandom); mix_gain = 8'($urandom);
        bypass = ~byp;
        vcnt = 0; vpos = -1; bcnt = 0; sl = '0; sr = '0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge mclk);
            if (out_valid === 1'b1) begin vcnt++; vpos = k; end
            if (busy === 1'b1) bcnt++;
            if (k == 7) begin sl = out_l; sr = out_r; end
        end
        chk({tag, "_vcnt"}, vcnt, 1);
        chk({tag, "_vpos"}, vpos, 7);
        chk({tag, "_busy"}, bcnt, 7);
        chk({tag, "_l"}, $signed(sl), el);
        chk({tag, "_r"}, $signed(sr), er);
        chk({tag, "_lhold"}, $signed(out_l), el);
        $display("frame %s in=(%0d,%0d) out=(%0d,%0d) exp=(%0d,%0d)",
                 tag, l, r, $signed(sl), $signed(sr), el, er);
    endtask

    task automatic model_run(input int l, input int r, input string tag);
        int el, er;
        model_frame(l, r, el, er);
        run_frame(l, r, el, er, tag);
    endtask

    task automatic do_reset();
        @(negedge mclk);
        rst_n = 1'b0;
        ws_in = 1'b0;
        repeat (2) @(negedge mclk);
        chk("rst_out_l", $signed(out_l), 0);
        chk("rst_out_r", $signed(out_r), 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        nfr = 0;
    endtask

    int e2l [0:7];
    int e3l [0:6];
    int vcnt_r;

    initial begin
        rst_n = 1'b0; ws_in = 1'b0; in_l = '0; in_r = '0;
        delay_len = '0; fb_gain = '0; mix_gain = '0; bypass = 1'b0;
        nfr = 0;

        // 1: effect off, dry passthrough
        dl = 0; fb = 0; mix = 0; byp = 0;
        do_reset();
        run_frame(1000, -1000, 1000, -1000, "t1");

        // 2: single echo at delay 4, half mix
        do_reset();
        dl = 4; mix = 128; fb = 0; byp = 0;
        e2l = '{16000, 0, 0, 0, 8000, 0, 0, 0};
        for (int i = 0; i < 8; i++)
            run_frame((i == 0) ? 16000 : 0, 0, e2l[i], 0, $sformatf("t2f%0d", i));

        // 3: decaying feedback echoes
        do_reset();
        dl = 2; fb = 128; mix = 255; byp = 0;
        e3l = '{16384, 0, 16320, 0, 8160, 0, 4080};
        for (int i = 0; i < 7; i++)
            run_frame((i == 0) ? 16384 : 0, 0, e3l[i], 0, $sformatf("t3f%0d", i));

        // 4: saturation both ways, floor rounding, bypass
        do_reset();
        dl = 1; mix = 255; fb = 0; byp = 0;
        run_frame(30000, -1000, 30000, -1000, "t4f0");
        run_frame(30000, -1000, 32767, -1997, "t4f1");
        run_frame(-30000, 0, -118, -997, "t4f2");
        run_frame(-30000, 0, -32768, 0, "t4f3");
        byp = 1;
        run_frame(5000, 0, 5000, 0, "t4f4");
        byp = 0;
        run_frame(0, 0, 4980, 0, "t4f5");

        // 5: fill RAM with random data, then reset; guard must hide it
        dl = 0; mix = 0; fb = 0; byp = 0;
        for (int i = 0; i < 128; i++)
            model_run(int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768,
                      $sformatf("pre%0d", i));
        do_reset();
        dl = 100; mix = 200; fb = 64; byp = 0;
        for (int i = 0; i < 140; i++)
            model_run(i * 211 - 15000, 12000 - i * 173, $sformatf("t5f%0d", i));

        // 6: shorter delay across the wrapped pointer, then reset mid-frame
        dl = 15; mix = 180; fb = 100;
        for (int i = 0; i < 5; i++)
            model_run(i * 500 + 300, -i * 700 - 100, $sformatf("t6f%0d", i));
        @(negedge mclk);
        ws_in = 1'b1;
        @(negedge mclk);
        ws_in = 1'b0;
        in_l = 16'(7777); in_r = 16'(-7777);
        repeat (3) @(negedge mclk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_l", $signed(out_l), 0);
        chk("mid_rst_r", $signed(out_r), 0);
        chk("mid_rst_busy", busy, 0);
        vcnt_r = 0;
        repeat (6) begin
            @(negedge mclk);
            if (out_valid !== 1'b0) vcnt_r++;
        end
        chk("mid_rst_novalid", vcnt_r, 0);
        rst_n = 1'b1;
        nfr = 0;
        for (int i = 0; i < 20; i++)
            model_run(i * 900 - 4000, 3000 - i * 250, $sformatf("t6r%0d", i));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
